// File: rtl/nn_addr_pkg.sv
// Shared types and default widths for the neural-network address sequencers.
package nn_addr_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nn_wrap_counter.sv
// Index counter with synchronous clear (priority over enable) and a compare against a terminal value.
module nn_wrap_counter #(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/layer_addr_sequencer.sv
// Walks weight/input/output addresses for one layer pass, one beat per addr_valid/addr_ready handshake.
// LAYER_ADDR_SEQ_BIAS_EN adds a trailing bias beat to every output neuron.
module layer_addr_sequencer
    import nn_addr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_in,
    input  logic [CNT_W-1:0]  n_out,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              beat_last,
    output logic              beat_bias,
    output logic              busy,
    output logic              done
);

    state_t state, state_nxt;

    logic [CNT_W-1:0]  n_in_r, n_out_r;
    logic [ADDR_W-1:0] w_base_r, in_base_r, out_base_r, w_cnt;
    logic [CNT_W-1:0]  in_idx, out_idx, in_term, out_term;
    logic              in_at_term, out_at_term;
    logic              launch, accept, neuron_end;

    assign launch     = (state == IDLE) && start && !abort;
    assign accept     = (state == RUN) && addr_ready;
    assign neuron_end = accept && in_at_term;

    // With the bias beat enabled the neuron ends one index later, on in_idx == n_in.
`ifdef LAYER_ADDR_SEQ_BIAS_EN
    assign in_term = n_in_r;
`else
    assign in_term = n_in_r - CNT_W'(1);
`endif
    assign out_term = n_out_r - CNT_W'(1);

    nn_wrap_counter #(.W(CNT_W)) u_in_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (launch || neuron_end),
        .en      (accept),
        .term    (in_term),
        .cnt     (in_idx),
        .at_term (in_at_term)
    );

    nn_wrap_counter #(.W(CNT_W)) u_out_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (launch),
        .en      (neuron_end),
        .term    (out_term),
        .cnt     (out_idx),
        .at_term (out_at_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            n_in_r     <= '0;
            n_out_r    <= '0;
            w_base_r   <= '0;
            in_base_r  <= '0;
            out_base_r <= '0;
            w_cnt      <= '0;
        end else if (launch) begin
            n_in_r     <= n_in;
            n_out_r    <= n_out;
            w_base_r   <= w_base;
            in_base_r  <= in_base;
            out_base_r <= out_base;
            w_cnt      <= '0;
        end else if (accept) begin
            w_cnt      <= w_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_valid = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        beat_last  = 1'b0;
        beat_bias  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_in == '0 || n_out == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                addr_valid = 1'b1;
                beat_last  = in_at_term;
`ifdef LAYER_ADDR_SEQ_BIAS_EN
                beat_bias  = in_at_term;
`endif
                if (neuron_end && out_at_term) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
        // State only settles at the next edge, so outputs are forced quiet for the whole reset window.
        if (reset) begin
            addr_valid = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
            beat_last  = 1'b0;
            beat_bias  = 1'b0;
        end
    end

    assign w_addr   = reset ? '0 : w_base_r + w_cnt;
    assign in_addr  = reset ? '0 : in_base_r + ADDR_W'(in_idx);
    assign out_addr = reset ? '0 : out_base_r + ADDR_W'(out_idx);

endmodule
